datamem_arbiter: RTL
====================

// Module: datamem_arbiter
// PURPOSE
//  Shares the single-port 16x8 data memory between the multicycle CPU datapath and a debug/loader port.
//  Sits between the control unit/datapath and the data memory; drives the memory's run, c17, write_select, inp, read_select.
//  CPU has fixed priority; a starvation counter guarantees the debug port a slot within STARVE_LIMIT cycles by stalling the CPU.
// PARAMETERS
//  ADDR_W        4   address width (memory depth = 2**ADDR_W = 16)
//  DATA_W        8   data width
//  STARVE_LIMIT  4   consecutive denied debug-request cycles before debug wins over CPU (1..15)
// PORTS
//  clock            in   1       system clock, all state on rising edge
//  reset            in   1       synchronous, active-high
//  cpu_en           in   1       CPU accesses memory this cycle (memory run)
//  cpu_we           in   1       CPU write enable (c17)
//  cpu_waddr        in   ADDR_W  CPU write address
//  cpu_wdata        in   DATA_W  CPU write data
//  cpu_raddr        in   ADDR_W  CPU read address
//  cpu_stall        out  1       CPU access in this cycle was NOT performed; CPU must hold and retry
//  dbg_req          in   1       debug access request, held with dbg_we/addr/wdata until dbg_gnt
//  dbg_we           in   1       1 = write, 0 = read
//  dbg_addr         in   ADDR_W  debug address (read and write)
//  dbg_wdata        in   DATA_W  debug write data
//  dbg_gnt          out  1       access issued this cycle (combinational, 1-cycle)
//  dbg_rvalid       out  1       registered 1-cycle pulse: dbg_rdata valid
//  dbg_rdata        out  DATA_W  captured read data, held until next debug read completes
//  mem_run, mem_c17 out  1       to data memory
//  mem_write_select out  ADDR_W  to data memory
//  mem_read_select  out  ADDR_W  to data memory
//  mem_inp          out  DATA_W  to data memory
//  mem_rdata        in   DATA_W  data memory output (registered in memory: valid cycle after access)
//  clr_start        in   1       (ARB_MEMCLR_EN only) start memory clear
//  clr_busy         out  1       (ARB_MEMCLR_EN only) clear in progress
// BEHAVIOUR
//  Reset: state S_IDLE, starve_cnt=0, dbg_rdata=0, dbg_rvalid=0; combinational outputs 0 while no access.
//  States: S_IDLE, S_DBG_RSP, S_CLR. Reset mid-operation abandons any read/clear; no dbg_rvalid issued.
//  S_IDLE: debug wins iff dbg_req && (!cpu_en || starve_cnt==STARVE_LIMIT); else CPU passes through if cpu_en.
//   debug win: mem_* driven from dbg (read_select=write_select=dbg_addr, c17=dbg_we), mem_run=1, dbg_gnt=1,
//     cpu_stall=cpu_en, starve_cnt<=0; read -> S_DBG_RSP, write -> stay S_IDLE.
//   CPU win: mem_* from cpu_*, mem_run=1; starve_cnt<=min(starve_cnt+1,STARVE_LIMIT) if dbg_req, else 0.
//   neither: mem_run=0, mem_c17=0 (memory output held).
//  S_DBG_RSP: no debug grant; CPU served as in S_IDLE (no stall, starve_cnt frozen); dbg_rdata<=mem_rdata
//   at edge, dbg_rvalid=1 next cycle; -> S_IDLE. Debug read latency: gnt cycle N -> dbg_rvalid cycle N+2.
//  CPU read latency unchanged (data in cycle after its unstalled access). A stalled cycle performs nothing for CPU.
//  Back-to-back debug: writes may be granted every cycle CPU idle; reads at most every 2nd cycle.
// CONFIGURATION
//  ARB_MEMCLR_EN defined: clr_start/clr_busy ports exist; clr_start in S_IDLE (highest priority, over debug and CPU)
//   -> S_CLR for 16 cycles writing 0 to addr 0..15 (mem_run=1, mem_c17=1, mem_inp=0); cpu_stall=cpu_en, dbg_gnt=0,
//   clr_busy=1; clr_start ignored while busy; after addr 15 -> S_IDLE; starve_cnt keeps counting during S_CLR.
//  Not defined: ports absent, S_CLR unreachable/omitted, no clear capability.
// STRUCTURE
//  Package datamem_arb_pkg: ADDR_W/DATA_W defaults, state encoding (S_IDLE/S_DBG_RSP/S_CLR), DEPTH constant.
//  Sub-module arb_starve_counter: saturating counter (inc, clr, sat flag) parameterised by STARVE_LIMIT.
//  Arbiter top holds FSM, output muxes, dbg_rdata capture; instantiated next to datamem in the datapath.
// TESTING
//  1 cpu_en=1 we=1 waddr=3 wdata=8'hA5, then raddr=3 -> mem_rdata=8'hA5 next cycle, cpu_stall never 1.
//  2 cpu_en=0, dbg read addr 3 -> dbg_gnt cycle N, dbg_rvalid cycle N+2 with dbg_rdata=8'hA5.
//  3 cpu_en=1 continuously, dbg_req write addr 7=8'h3C -> gnt exactly on 5th request cycle (STARVE_LIMIT=4), cpu_stall=1 that cycle only.
//  4 dbg read granted, CPU writes addr 3=8'h11 in S_DBG_RSP -> dbg_rdata=8'hA5 (old), memory then reads 8'h11.
//  5 reset asserted in S_DBG_RSP -> no dbg_rvalid, dbg_rdata=0, state S_IDLE next cycle.
//  6 (ARB_MEMCLR_EN) clr_start with cpu_en=1 -> clr_busy 16 cycles, cpu_stall=1 throughout, all 16 addresses read 0.

Source files
------------

// File: rtl/datamem_arb_pkg.sv
// Shared constants and state encoding for the data-memory arbiter.
// Optional memory-clear feature is selected with the ARB_MEMCLR_EN macro.
package datamem_arb_pkg;

  localparam int DEF_ADDR_W       = 4;
  localparam int DEF_DATA_W       = 8;
  localparam int MEM_DEPTH        = 1 << DEF_ADDR_W;
  localparam int DEF_STARVE_LIMIT = 4;
  // Wide enough for any STARVE_LIMIT in 1..15.
  localparam int STARVE_CNT_W     = 4;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DBG_RSP = 2'd1,
    S_CLR     = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating count of consecutive cycles the debug port was denied.
// sat tells the arbiter that debug must win the next contended cycle.
module arb_starve_counter
  import datamem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_CNT_W-1:0] count;

  // Count denied cycles, holding at the limit; clear wins over increment.
  always_ff @(posedge clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset || clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

  assign sat = (count == STARVE_CNT_W'(STARVE_LIMIT));

endmodule

// File: rtl/datamem_arbiter.sv
// Arbiter sharing the single-port data memory between the CPU datapath
// (fixed priority) and a debug/loader port with starvation protection.
// Define ARB_MEMCLR_EN to add the clr_start/clr_busy memory-clear engine.
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_run,
  output logic              mem_c17,
  output logic [ADDR_W-1:0] mem_write_select,
  output logic [ADDR_W-1:0] mem_read_select,
  output logic [DATA_W-1:0] mem_inp,
`ifdef ARB_MEMCLR_EN
  input  logic              clr_start,
  output logic              clr_busy,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state, state_nxt;
  logic       starve_inc, starve_clr, starve_sat;
  logic       capture;

`ifdef ARB_MEMCLR_EN
  logic [ADDR_W-1:0] clr_addr;
`endif

  arb_starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clock (clock),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .sat   (starve_sat)
  );

  // Next-state decode plus memory-port steering for the winner of this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_nxt        = state;
    mem_run          = 1'b0;
    mem_c17          = 1'b0;
    mem_write_select = '0;
    mem_read_select  = '0;
    mem_inp          = '0;
    cpu_stall        = 1'b0;
    dbg_gnt          = 1'b0;
    starve_inc       = 1'b0;
    starve_clr       = 1'b0;
    capture          = 1'b0;
`ifdef ARB_MEMCLR_EN
    clr_busy         = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
`ifdef ARB_MEMCLR_EN
        if (clr_start) begin
          // Clear pre-empts everyone; this cycle performs no access.
          cpu_stall  = cpu_en;
          starve_inc = dbg_req;
          starve_clr = !dbg_req;
          state_nxt  = S_CLR;
        end else
`endif
        if (dbg_req && (!cpu_en || starve_sat)) begin
          mem_run          = 1'b1;
          mem_c17          = dbg_we;
          mem_write_select = dbg_addr;
          mem_read_select  = dbg_addr;
          mem_inp          = dbg_wdata;
          dbg_gnt          = 1'b1;
          cpu_stall        = cpu_en;
          starve_clr       = 1'b1;
          state_nxt        = dbg_we ? S_IDLE : S_DBG_RSP;
        end else if (cpu_en) begin
          mem_run          = 1'b1;
          mem_c17          = cpu_we;
          mem_write_select = cpu_waddr;
          mem_read_select  = cpu_raddr;
          mem_inp          = cpu_wdata;
          starve_inc       = dbg_req;
          starve_clr       = !dbg_req;
        end else begin
          starve_clr = 1'b1;
        end
      end
      S_DBG_RSP: begin
        // Memory output now holds the debug read data; CPU may still proceed.
        if (cpu_en) begin
          mem_run          = 1'b1;
          mem_c17          = cpu_we;
          mem_write_select = cpu_waddr;
          mem_read_select  = cpu_raddr;
          mem_inp          = cpu_wdata;
        end
        capture   = 1'b1;
        state_nxt = S_IDLE;
      end
`ifdef ARB_MEMCLR_EN
      S_CLR: begin
        mem_run          = 1'b1;
        mem_c17          = 1'b1;
        mem_write_select = clr_addr;
        mem_read_select  = clr_addr;
        mem_inp          = '0;
        cpu_stall        = cpu_en;
        clr_busy         = 1'b1;
        starve_inc       = dbg_req;
        starve_clr       = !dbg_req;
        if (clr_addr == ADDR_W'((1 << ADDR_W) - 1)) begin
          state_nxt = S_IDLE;
        end
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register, debug read capture and its one-cycle valid pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      dbg_rdata  <= '0;
      dbg_rvalid <= 1'b0;
    end else begin
      state      <= state_nxt;
      dbg_rvalid <= capture;
      if (capture) begin
        dbg_rdata <= mem_rdata;
      end
    end
  end

`ifdef ARB_MEMCLR_EN
  // Clear address walks 0..DEPTH-1 while in S_CLR and rests at 0 otherwise.
  always_ff @(posedge clock) begin
    if (reset || state != S_CLR) begin
      clr_addr <= '0;
    end else begin
      clr_addr <= clr_addr + 1'b1;
    end
  end
`endif

endmodule
